// File: rtl/i2c_codec_responder_if.sv
// i2c_codec_responder_if
// Decoded register-write port of the codec-side I2C responder.
//   o_wr_valid  one-cycle strobe: a decoded write is available
//   o_reg_addr  7-bit register address of the last accepted write
//   o_reg_data  9-bit register data of the last accepted write
//   o_wr_count  accepted-write counter, wraps 15 -> 0
//   o_busy      high from START until STOP or abort
// The master modport is the responder, which produces the writes.
// The slave modport is whatever consumes them.
interface i2c_codec_responder_if;
  logic       o_wr_valid;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;
  logic [3:0] o_wr_count;
  logic       o_busy;

  modport master (
    output o_wr_valid,
    output o_reg_addr,
    output o_reg_data,
    output o_wr_count,
    output o_busy
  );

  modport slave (
    input o_wr_valid,
    input o_reg_addr,
    input o_reg_data,
    input o_wr_count,
    input o_busy
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder
// I2C target that models the audio codec control port. It accepts the 3-byte write
// [dev addr + W][reg addr << 1 | data[8]][data[7:0]], ACKs each byte of a matching
// write, and presents one decoded register write per transfer.
// SCL and SDA are oversampled on i_clk, so i_clk must be at least 8x the SCL rate.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-low
//   i_sclk   I2C clock from the initiator (asynchronous)
//   io_sdat  I2C data, open-drain: this block drives only 0 or 'z
//   wr_if    decoded write port (valid strobe, addr, data, count, busy)
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2       // at least 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sclk,
  inout  wire                           io_sdat,
  i2c_codec_responder_if.master         wr_if
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_WAIT_P,
    ST_IGNORE
  } state_t;

  state_t                 state_q,    state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [2:0]             bit_cnt_q,  bit_cnt_d;
  logic [7:0]             shreg_q,    shreg_d;
  logic [7:0]             b1_q,       b1_d;
  logic                   sda_drv_q,  sda_drv_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [6:0]             reg_addr_q, reg_addr_d;
  logic [8:0]             reg_data_q, reg_data_d;
  logic [3:0]             wr_count_q, wr_count_d;
  logic                   busy_q,     busy_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_evt, stop_evt;
  logic [7:0] byte_in;

  // Open-drain: pull low for ACK, otherwise leave the line to the pull-up.
  assign io_sdat = sda_drv_q ? 1'b0 : 1'bz;

  assign wr_if.o_wr_valid = wr_valid_q;
  assign wr_if.o_reg_addr = reg_addr_q;
  assign wr_if.o_reg_data = reg_data_q;
  assign wr_if.o_wr_count = wr_count_q;
  assign wr_if.o_busy     = busy_q;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_sclk};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], io_sdat};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    b1_d       = b1_q;
    sda_drv_d  = sda_drv_q;
    wr_valid_d = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    wr_count_d = wr_count_q;
    busy_d     = busy_q;

    scl_s    = scl_sync_q[SYNC_STAGES-1];
    sda_s    = sda_sync_q[SYNC_STAGES-1];
    scl_rise = scl_s & ~scl_prev_q;
    scl_fall = ~scl_s & scl_prev_q;
    // START/STOP need SCL stable high across the SDA edge; an SCL edge in the
    // same cycle wins and suppresses them.
    start_evt = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
    stop_evt  = ~sda_prev_q & sda_s & scl_s & scl_prev_q;
    byte_in   = {shreg_q[6:0], sda_s};

    if (start_evt) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
      sda_drv_d = 1'b0;
    end else if (stop_evt) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b0;
      sda_drv_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;   // wraps to 0 after the 8th bit
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_ADDR: begin
                  // A read request or foreign address is never ACKed.
                  if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) state_d = ST_ACK_A;
                  else                                          state_d = ST_IGNORE;
                end
                ST_BYTE1: begin
                  b1_d    = byte_in;
                  state_d = ST_ACK_1;
                end
                default: state_d = ST_ACK_2;
              endcase
            end
          end
        end

        // First SCL fall after bit 8 pulls SDA low; the next fall releases it.
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          if (scl_fall) begin
            if (!sda_drv_q) begin
              sda_drv_d = 1'b1;
            end else begin
              sda_drv_d = 1'b0;
              case (state_q)
                ST_ACK_A: state_d = ST_BYTE1;
                ST_ACK_1: state_d = ST_BYTE2;
                default: begin
                  reg_addr_d = b1_q[7:1];
                  reg_data_d = {b1_q[0], shreg_q};
                  wr_valid_d = 1'b1;
                  wr_count_d = wr_count_q + 4'd1;
                  state_d    = ST_WAIT_P;
                end
              endcase
            end
          end
        end

        // IDLE, WAIT_P and IGNORE only leave on START/STOP, handled above.
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      // Synchronizers start at the idle bus level so reset release does not
      // look like a START.
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      b1_q       <= 8'h00;
      sda_drv_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      reg_addr_q <= 7'h00;
      reg_data_q <= 9'h000;
      wr_count_q <= 4'h0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, regardless of statement order.
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      b1_q       <= b1_d;
      sda_drv_q  <= sda_drv_d;
      wr_valid_q <= wr_valid_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder
// Directed bench for i2c_codec_responder: a bit-banged I2C initiator with a
// pulled-up open-drain SDA line. Expected values are hand-computed constants.
module tb_i2c_codec_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic tb_sda_rel = 1'b1;   // 1 = bench releases SDA, 0 = bench pulls low
  wire  sda;

  assign sda = tb_sda_rel ? 1'bz : 1'b0;
  pullup (sda);

  i2c_codec_responder_if wr_if ();

  i2c_codec_responder #(
    .DEV_ADDR    (7'h1A),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sclk  (scl),
    .io_sdat (sda),
    .wr_if   (wr_if.master)
  );

  always #5 clk = ~clk;

  int vec_cnt     = 0;
  int err_cnt     = 0;
  int strobe_cnt  = 0;
  int dut_low_cnt = 0;

  // Strobe count: a 2-cycle strobe would count twice.
  always @(negedge clk) begin
    if (wr_if.o_wr_valid === 1'b1) strobe_cnt++;
    if (tb_sda_rel && sda === 1'b0) dut_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    tb_sda_rel = 1'b1;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(6);
    tb_sda_rel = 1'b0;
    wait_clk(6);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(4);
    tb_sda_rel = 1'b0;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(6);
    tb_sda_rel = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wait_clk(4);
      tb_sda_rel = b[7-i];
      wait_clk(4);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
    end
  endtask

  // Ninth clock: release SDA and sample it mid-high. 0 = ACK, 1 = NACK.
  task automatic ack_bit(output logic a);
    wait_clk(4);
    tb_sda_rel = 1'b1;
    wait_clk(4);
    scl = 1'b1;
    wait_clk(4);
    a = sda;
    wait_clk(4);
    scl = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] b1, input logic [7:0] b2,
                            output logic [2:0] acks, output logic busy_before_stop);
    logic a;
    start_cond();
    send_bits(8'h34, 8); ack_bit(a); acks[2] = a;
    send_bits(b1, 8);    ack_bit(a); acks[1] = a;
    send_bits(b2, 8);    ack_bit(a); acks[0] = a;
    busy_before_stop = wr_if.o_busy;
    stop_cond();
  endtask

  logic [15:0] init_seq [10] = '{16'h1E00, 16'h0C10, 16'h0E42, 16'h0D55, 16'h0A00,
                                 16'h0817, 16'h0017, 16'h0217, 16'h0479, 16'h1201};
  logic [6:0] exp_addr [10]  = '{7'h0F, 7'h06, 7'h07, 7'h06, 7'h05,
                                 7'h04, 7'h00, 7'h01, 7'h02, 7'h09};
  logic [8:0] exp_data [10]  = '{9'h000, 9'h010, 9'h042, 9'h155, 9'h000,
                                 9'h017, 9'h017, 9'h017, 9'h079, 9'h001};

  initial begin
    logic [2:0] acks;
    logic       busy;
    logic       a;
    int         s0;

    // Reset state
    wait_clk(5);
    check("rst_valid", 32'(wr_if.o_wr_valid), 32'd0);
    check("rst_addr",  32'(wr_if.o_reg_addr), 32'd0);
    check("rst_data",  32'(wr_if.o_reg_data), 32'd0);
    check("rst_count", 32'(wr_if.o_wr_count), 32'd0);
    check("rst_busy",  32'(wr_if.o_busy),     32'd0);
    check("rst_sda",   32'(sda),              32'd1);
    rst = 1'b1;
    wait_clk(4);

    // 1: single write 0x34,0x00,0x97
    s0 = strobe_cnt;
    write_word(8'h00, 8'h97, acks, busy);
    check("t1_acks",    32'(acks),             32'b000);
    check("t1_busy",    32'(busy),             32'd1);
    check("t1_idle",    32'(wr_if.o_busy),     32'd0);
    check("t1_strobes", 32'(strobe_cnt - s0),  32'd1);
    check("t1_addr",    32'(wr_if.o_reg_addr), 32'h00);
    check("t1_data",    32'(wr_if.o_reg_data), 32'h097);
    check("t1_count",   32'(wr_if.o_wr_count), 32'd1);

    // Fresh counter for the init sequence
    rst = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(4);
    check("t2_count0", 32'(wr_if.o_wr_count), 32'd0);

    // 2: ten-word init sequence
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      write_word(init_seq[i][15:8], init_seq[i][7:0], acks, busy);
      check($sformatf("t2_acks_%0d", i), 32'(acks),             32'b000);
      check($sformatf("t2_addr_%0d", i), 32'(wr_if.o_reg_addr), 32'(exp_addr[i]));
      check($sformatf("t2_data_%0d", i), 32'(wr_if.o_reg_data), 32'(exp_data[i]));
    end
    check("t2_strobes", 32'(strobe_cnt - s0),  32'd10);
    check("t2_count",   32'(wr_if.o_wr_count), 32'd10);

    // 3: wrong address and read request are ignored
    s0 = strobe_cnt;
    dut_low_cnt = 0;
    start_cond();
    send_bits(8'h36, 8); ack_bit(a);
    check("t3_nack_wrong", 32'(a), 32'd1);
    send_bits(8'h00, 8); ack_bit(a);
    check("t3_nack_data",  32'(a), 32'd1);
    check("t3_busy",       32'(wr_if.o_busy), 32'd1);
    stop_cond();
    check("t3_idle",       32'(wr_if.o_busy), 32'd0);
    start_cond();
    send_bits(8'h35, 8); ack_bit(a);
    check("t3_nack_read",  32'(a), 32'd1);
    stop_cond();
    check("t3_idle2",      32'(wr_if.o_busy),      32'd0);
    check("t3_no_drive",   32'(dut_low_cnt),       32'd0);
    check("t3_strobes",    32'(strobe_cnt - s0),   32'd0);
    check("t3_hold_addr",  32'(wr_if.o_reg_addr),  32'h09);
    check("t3_hold_data",  32'(wr_if.o_reg_data),  32'h001);
    check("t3_count",      32'(wr_if.o_wr_count),  32'd10);

    // 4: repeated START 4 bits into BYTE1 discards the partial word
    s0 = strobe_cnt;
    start_cond();
    send_bits(8'h34, 8); ack_bit(a);
    check("t4_ack_addr", 32'(a), 32'd0);
    send_bits(8'hF0, 4);
    write_word(8'h0A, 8'h5A, acks, busy);
    check("t4_acks",    32'(acks),             32'b000);
    check("t4_strobes", 32'(strobe_cnt - s0),  32'd1);
    check("t4_addr",    32'(wr_if.o_reg_addr), 32'h05);
    check("t4_data",    32'(wr_if.o_reg_data), 32'h05A);
    check("t4_count",   32'(wr_if.o_wr_count), 32'd11);

    // 5: a 4th byte is NACKed and produces no extra strobe
    s0 = strobe_cnt;
    start_cond();
    send_bits(8'h34, 8); ack_bit(a); acks[2] = a;
    send_bits(8'h08, 8); ack_bit(a); acks[1] = a;
    send_bits(8'h3C, 8); ack_bit(a); acks[0] = a;
    send_bits(8'hFF, 8); ack_bit(a);
    stop_cond();
    check("t5_acks",    32'(acks),             32'b000);
    check("t5_nack4",   32'(a),                32'd1);
    check("t5_strobes", 32'(strobe_cnt - s0),  32'd1);
    check("t5_addr",    32'(wr_if.o_reg_addr), 32'h04);
    check("t5_data",    32'(wr_if.o_reg_data), 32'h03C);
    check("t5_count",   32'(wr_if.o_wr_count), 32'd12);

    // 6: reset while the address ACK is being driven
    start_cond();
    send_bits(8'h34, 8);
    tb_sda_rel = 1'b1;
    wait_clk(6);
    check("t6_ack_driven", 32'(sda), 32'd0);
    rst = 1'b0;
    wait_clk(1);
    check("t6_sda_rel", 32'(sda),              32'd1);
    check("t6_busy",    32'(wr_if.o_busy),     32'd0);
    check("t6_count",   32'(wr_if.o_wr_count), 32'd0);
    check("t6_addr",    32'(wr_if.o_reg_addr), 32'd0);
    check("t6_data",    32'(wr_if.o_reg_data), 32'd0);
    check("t6_valid",   32'(wr_if.o_wr_valid), 32'd0);
    rst = 1'b1;
    wait_clk(4);
    stop_cond();

    // Counter wraps 15 -> 0
    for (int i = 0; i < 15; i++) write_word(8'h02, 8'h11, acks, busy);
    check("wrap_15", 32'(wr_if.o_wr_count), 32'd15);
    write_word(8'h03, 8'h22, acks, busy);
    check("wrap_0",    32'(wr_if.o_wr_count), 32'd0);
    check("wrap_data", 32'(wr_if.o_reg_data), 32'h122);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
